// File: rtl/capcnt_ctrl_pkg.sv
// Shared types and constants for the capcnt capture scheduler.
// Imported by the scheduler top and its timer.
package capcnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam int CHAN_W = 4;
    localparam int OVR_W  = 8;
    localparam int LAT_W  = 3;

    localparam logic [OVR_W-1:0] OVR_MAX = 8'hFF;

    function automatic logic [OVR_W-1:0] sat_inc(
        input logic [OVR_W-1:0] v
    );
        return (v == OVR_MAX) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/capcnt_ctrl_timer.sv
// Reloadable period down-counter for the capture scheduler.
// Emits a one-cycle tick on reaching zero and reloads in the same cycle.
module capcnt_ctrl_timer #(
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] cnt;
    logic [PW-1:0] reload;

    assign reload = (period == '0) ? '0 : period - PW'(1);
    assign tick   = run && (cnt == '0);

    // While stopped the counter tracks the reload value, so the first
    // tick after starting arrives exactly one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - PW'(1);
        end
    end

endmodule

// File: rtl/capcnt_ctrl.sv
// Capture scheduler and readout sequencer for a bank of capcnt channels.
// One shared cap strobe per tick, then N captured words on a valid/ready stream.
module capcnt_ctrl
    import capcnt_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int PW      = 24,
    parameter int CAP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              src_ext,
    input  logic [PW-1:0]     period,
    input  logic              ext_tick,
    output logic              cap,
    input  logic [N*W-1:0]    cnt_cap,
    output logic [W-1:0]      out_data,
    output logic [CHAN_W-1:0] out_chan,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovr,
    input  logic              ovr_clr,
    output logic [OVR_W-1:0]  ovr_cnt
);

    localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(N - 1);
    localparam logic [LAT_W-1:0]  LAT_END = LAT_W'(CAP_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [LAT_W-1:0]   wcnt;
    logic               tmr_run;
    logic               tmr_tick;
    logic               tick;
    logic               drop;
    logic               load0;
    logic               adv;
    logic [CHAN_W-1:0]  nxt_ch;
    logic [W-1:0]       words [16];

    assign tmr_run = en && !src_ext && (period != '0);

    capcnt_ctrl_timer #(
        .PW (PW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (tmr_run),
        .period (period),
        .tick   (tmr_tick)
    );

    assign tick      = en && (src_ext ? ext_tick : tmr_tick);
    assign cap       = (state == ST_CAP);
    assign out_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    // A tick arriving mid-frame is discarded so the captured set survives.
    assign drop      = tick && busy;

    for (genvar i = 0; i < 16; i++) begin : g_words
        if (i < N) begin : g_used
            assign words[i] = cnt_cap[i*W +: W];
        end else begin : g_pad
            assign words[i] = '0;
        end
    end

    assign nxt_ch = load0 ? '0 : out_chan + CHAN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load0     = 1'b0;
        adv       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_CAP;
            end
            ST_CAP: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt == LAT_END) begin
                    load0     = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_chan == LAST_CH) state_nxt = ST_IDLE;
                    else                     adv       = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= '0;
            out_data <= '0;
            out_chan <= '0;
            out_last <= 1'b0;
        end else begin
            if (state == ST_WAIT && wcnt != LAT_END) wcnt <= wcnt + LAT_W'(1);
            else                                     wcnt <= '0;
            if (load0 || adv) begin
                out_data <= words[nxt_ch];
                out_chan <= nxt_ch;
                out_last <= (nxt_ch == LAST_CH);
            end
        end
    end

    // Clear takes priority, but a drop in the same cycle still registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr     <= 1'b0;
            ovr_cnt <= '0;
        end else if (ovr_clr) begin
            ovr     <= drop;
            ovr_cnt <= drop ? OVR_W'(1) : '0;
        end else if (drop) begin
            ovr     <= 1'b1;
            ovr_cnt <= sat_inc(ovr_cnt);
        end
    end

endmodule
